// File: rtl/scoreboard_stall_unit.sv
// Countdown scoreboard beside the ID stage: stalls reads of registers whose results are not yet deliverable.
// Optional stall statistics are built when STALL_STATS_EN is defined.
module scoreboard_stall_unit #(
    parameter int NREGS    = 32,
    parameter int RW       = 5,
    parameter int CW       = 3,
    parameter int ALU_LAT  = 1,
    parameter int LOAD_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [5:0]       id_op,
    input  logic [RW-1:0]    id_rs,
    input  logic [RW-1:0]    id_rt,
    input  logic [RW-1:0]    id_rd,
    input  logic             hold,
    input  logic             flush,
    output logic             stall,
    output logic             issue,
    output logic [NREGS-1:0] pending
`ifdef STALL_STATS_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      load_stalls,
    output logic [31:0]      branch_stalls
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    typedef struct packed {
        logic          reads_rs;
        logic          reads_rt;
        logic          writes;
        logic          is_branch;
        logic          is_load;
        logic [RW-1:0] dest;
    } decode_t;

    decode_t       dec;
    logic [CW-1:0] cnt [NREGS];
    logic [CW-1:0] cnt_rs;
    logic [CW-1:0] cnt_rt;
    logic          rs_block;
    logic          rt_block;
    logic          load_dest;
    logic [CW-1:0] lat;
    logic [CW-1:0] dest_dec;
    logic [CW-1:0] dest_next;

    function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] v);
        return (v == '0) ? '0 : v - CW'(1);
    endfunction

    // NOTE: every output of a combinational block gets a default first, so no path leaves a latch behind.
    always_comb begin
        dec = '0;
        case (id_op)
            OP_RTYPE: begin
                dec.reads_rs = 1'b1;
                dec.reads_rt = 1'b1;
                dec.writes   = 1'b1;
                dec.dest     = id_rd;
            end
            OP_LW: begin
                dec.reads_rs = 1'b1;
                dec.writes   = 1'b1;
                dec.is_load  = 1'b1;
                dec.dest     = id_rt;
            end
            OP_SW: begin
                dec.reads_rs = 1'b1;
                dec.reads_rt = 1'b1;
            end
            OP_ADDI, OP_SLTI, OP_ORI: begin
                dec.reads_rs = 1'b1;
                dec.writes   = 1'b1;
                dec.dest     = id_rt;
            end
            OP_LUI: begin
                dec.writes = 1'b1;
                dec.dest   = id_rt;
            end
            OP_BEQ, OP_BNE: begin
                dec.reads_rs  = 1'b1;
                dec.reads_rt  = 1'b1;
                dec.is_branch = 1'b1;
            end
            OP_J:    dec = '0;
            default: dec = '0;
        endcase
    end

    // Branches resolve in ID and need the value now; EX consumers can take a forward one cycle early.
    always_comb begin
        cnt_rs   = cnt[id_rs];
        cnt_rt   = cnt[id_rt];
        rs_block = dec.reads_rs && (id_rs != '0) &&
                   (dec.is_branch ? (cnt_rs != '0) : (cnt_rs > CW'(1)));
        rt_block = dec.reads_rt && (id_rt != '0) &&
                   (dec.is_branch ? (cnt_rt != '0) : (cnt_rt > CW'(1)));
        stall    = id_valid && !reset && (rs_block || rt_block);
        issue    = id_valid && !stall && !hold && !flush && !reset;
    end

    always_comb begin
        load_dest = issue && dec.writes && (dec.dest != '0);
        lat       = dec.is_load ? CW'(LOAD_LAT) : CW'(ALU_LAT);
        dest_dec  = sat_dec(cnt[dec.dest]);
        dest_next = (dest_dec > lat) ? dest_dec : lat;
    end

    // NOTE: the counters are reset because they are control state; a stale count would stall after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
        end else if (!hold) begin
            for (int r = 0; r < NREGS; r++) begin
                // NOTE: non-blocking updates let every counter see the pre-edge values of its neighbours.
                if (load_dest && (dec.dest == RW'(r))) cnt[r] <= dest_next;
                else                                   cnt[r] <= sat_dec(cnt[r]);
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NREGS; r++) pending[r] = (cnt[r] != '0);
    end

`ifdef STALL_STATS_EN
    logic lflag [NREGS];
    logic load_hit;
    logic dest_flag;

    // A WAW by an ALU op keeps the load flag only while the load's own remaining time still governs the count.
    always_comb begin
        dest_flag = dec.is_load || (lflag[dec.dest] && (dest_dec >= lat));
        load_hit  = (rs_block && lflag[id_rs]) || (rt_block && lflag[id_rt]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) lflag[r] <= 1'b0;
            stall_cycles  <= '0;
            load_stalls   <= '0;
            branch_stalls <= '0;
        end else if (!hold) begin
            for (int r = 0; r < NREGS; r++) begin
                if (load_dest && (dec.dest == RW'(r))) lflag[r] <= dest_flag;
            end
            if (stall)                  stall_cycles  <= stall_cycles + 32'd1;
            if (stall && load_hit)      load_stalls   <= load_stalls + 32'd1;
            if (stall && dec.is_branch) branch_stalls <= branch_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_scoreboard_stall_unit.sv
// Self-checking bench for scoreboard_stall_unit: vector table, directed hazard sequences, random vs a
// remaining-cycles reference model. Define STALL_STATS_EN to also check the statistics counters.
module tb_scoreboard_stall_unit;
    localparam int NREGS    = 32;
    localparam int RW       = 5;
    localparam int CW       = 3;
    localparam int ALU_LAT  = 1;
    localparam int LOAD_LAT = 2;

    localparam logic [5:0] RT  = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101, J = 6'b000010, ADDI = 6'b001000, SLTI = 6'b001010;
    localparam logic [5:0] LUI = 6'b001111, ORI = 6'b001101, BAD = 6'b111111;

    logic             clk = 1'b0;
    logic             reset = 1'b1, id_valid = 1'b0, hold = 1'b0, flush = 1'b0;
    logic [5:0]       id_op = '0;
    logic [RW-1:0]    id_rs = '0, id_rt = '0, id_rd = '0;
    logic             stall, issue;
    logic [NREGS-1:0] pending;
`ifdef STALL_STATS_EN
    logic [31:0]      stall_cycles, load_stalls, branch_stalls;
`endif

    always #5 clk = ~clk;

    scoreboard_stall_unit #(.NREGS(NREGS), .RW(RW), .CW(CW), .ALU_LAT(ALU_LAT), .LOAD_LAT(LOAD_LAT)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_op(id_op),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .hold(hold), .flush(flush),
        .stall(stall), .issue(issue), .pending(pending)
`ifdef STALL_STATS_EN
        , .stall_cycles(stall_cycles), .load_stalls(load_stalls), .branch_stalls(branch_stalls)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: cycles remaining until each register's value is in the register file,
    // plus the part of that wait owed to an outstanding load.
    int         rem [NREGS];
    int         rem_load [NREGS];
    bit         m_stall, m_issue, m_lstall, m_branch;
    logic [31:0] m_pend;
    int         m_sc = 0, m_ls = 0, m_bs = 0;

    function automatic void decode(input logic [5:0] op, output bit rrs, output bit rrt,
                                   output bit wr, output bit br, output bit ld, output int dst);
        rrs = 0; rrt = 0; wr = 0; br = 0; ld = 0; dst = 0;
        case (op)
            RT:               begin rrs = 1; rrt = 1; wr = 1; dst = int'(id_rd); end
            LW:               begin rrs = 1; wr = 1; ld = 1; dst = int'(id_rt); end
            SW:               begin rrs = 1; rrt = 1; end
            ADDI, SLTI, ORI:  begin rrs = 1; wr = 1; dst = int'(id_rt); end
            LUI:              begin wr = 1; dst = int'(id_rt); end
            BEQ, BNE:         begin rrs = 1; rrt = 1; br = 1; end
            default:          ;
        endcase
    endfunction

    function automatic bit not_ready(input int wait_cycles, input bit br);
        return br ? (wait_cycles > 0) : (wait_cycles > 1);
    endfunction

    task automatic model_eval();
        bit rrs, rrt, wr, br, ld, brs, brt;
        int dst;
        decode(id_op, rrs, rrt, wr, br, ld, dst);
        brs      = rrs && (id_rs != 0) && not_ready(rem[id_rs], br);
        brt      = rrt && (id_rt != 0) && not_ready(rem[id_rt], br);
        m_stall  = id_valid && !reset && (brs || brt);
        m_lstall = m_stall && ((brs && not_ready(rem_load[id_rs], br)) ||
                               (brt && not_ready(rem_load[id_rt], br)));
        m_branch = br;
        m_issue  = id_valid && !m_stall && !hold && !flush && !reset;
        for (int r = 0; r < NREGS; r++) m_pend[r] = (rem[r] != 0);
    endtask

    task automatic model_edge();
        bit rrs, rrt, wr, br, ld;
        int dst;
        decode(id_op, rrs, rrt, wr, br, ld, dst);
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin rem[r] = 0; rem_load[r] = 0; end
            m_sc = 0; m_ls = 0; m_bs = 0;
        end else if (!hold) begin
            if (m_stall) m_sc++;
            if (m_lstall) m_ls++;
            if (m_stall && m_branch) m_bs++;
            for (int r = 0; r < NREGS; r++) begin
                if (rem[r] > 0) rem[r]--;
                if (rem_load[r] > 0) rem_load[r]--;
            end
            if (m_issue && wr && dst != 0) begin
                if (rem[dst] < (ld ? LOAD_LAT : ALU_LAT)) rem[dst] = ld ? LOAD_LAT : ALU_LAT;
                if (ld && rem_load[dst] < LOAD_LAT) rem_load[dst] = LOAD_LAT;
            end
        end
    endtask

    // Drive at posedge+1, sample at posedge+3.
    task automatic apply(input bit v, input logic [5:0] op, input int rs, input int rt, input int rd,
                         input bit h, input bit f, input bit r);
        id_valid = v; id_op = op; hold = h; flush = f; reset = r;
        id_rs = rs[RW-1:0]; id_rt = rt[RW-1:0]; id_rd = rd[RW-1:0];
        model_eval();
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic check_model(input string tag);
        check({tag, "_stall"}, stall, m_stall);
        check({tag, "_issue"}, issue, m_issue);
        check({tag, "_pending"}, pending, m_pend);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            apply(0, RT, 0, 0, 0, 0, 0, 0);
            check_model("idle");
            tick();
        end
    endtask

    // Hold an instruction in ID until it issues; count its stall cycles within a bounded budget.
    task automatic run_until_issue(input string name, input logic [5:0] op, input int rs, input int rt,
                                   input int rd, input int exp_stalls);
        int  n = 0;
        bit  done = 0;
        for (int k = 0; k < 10 && !done; k++) begin
            apply(1, op, rs, rt, rd, 0, 0, 0);
            check_model(name);
            if (issue) done = 1;
            else if (stall) n++;
            tick();
        end
        if (!done) n = 99;
        check({name, "_stall_count"}, n, exp_stalls);
    endtask

    typedef struct {
        bit         v;
        logic [5:0] op;
        int         rs, rt, rd;
        bit         f;
        bit         e_stall, e_issue;
        logic [31:0] e_pend;
    } vec_t;

    function automatic vec_t mk(input bit v, input logic [5:0] op, input int rs, input int rt, input int rd,
                                input bit f, input bit es, input bit ei, input logic [31:0] ep);
        vec_t t;
        t.v = v; t.op = op; t.rs = rs; t.rt = rt; t.rd = rd; t.f = f;
        t.e_stall = es; t.e_issue = ei; t.e_pend = ep;
        return t;
    endfunction

    vec_t vt[$];
    logic [5:0] ops [11] = '{RT, LW, SW, BEQ, BNE, J, ADDI, SLTI, LUI, ORI, BAD};

    initial begin
        vt.push_back(mk(1, LW,   1, 5, 0, 0, 0, 1, 32'h0));
        vt.push_back(mk(1, RT,   5, 7, 6, 0, 1, 0, 32'h1 << 5));
        vt.push_back(mk(1, RT,   5, 7, 6, 0, 0, 1, 32'h1 << 5));
        vt.push_back(mk(0, RT,   0, 0, 0, 0, 0, 0, 32'h1 << 6));
        vt.push_back(mk(0, RT,   0, 0, 0, 0, 0, 0, 32'h0));
        vt.push_back(mk(1, LW,   0, 0, 0, 0, 0, 1, 32'h0));
        vt.push_back(mk(1, RT,   0, 0, 1, 0, 0, 1, 32'h0));
        vt.push_back(mk(0, RT,   0, 0, 0, 0, 0, 0, 32'h1 << 1));
        vt.push_back(mk(0, RT,   0, 0, 0, 0, 0, 0, 32'h0));
        vt.push_back(mk(1, LW,   1, 10, 0, 1, 0, 0, 32'h0));
        vt.push_back(mk(0, RT,   0, 0, 0, 0, 0, 0, 32'h0));
        vt.push_back(mk(1, LW,   1, 4, 0, 0, 0, 1, 32'h0));
        vt.push_back(mk(1, BAD,  4, 4, 4, 0, 0, 1, 32'h1 << 4));
        vt.push_back(mk(1, RT,   4, 4, 5, 0, 0, 1, 32'h1 << 4));
        vt.push_back(mk(0, RT,   0, 0, 0, 0, 0, 0, 32'h1 << 5));
        vt.push_back(mk(0, RT,   0, 0, 0, 0, 0, 0, 32'h0));
        vt.push_back(mk(1, LW,   1, 6, 0, 0, 0, 1, 32'h0));
        vt.push_back(mk(0, RT,   6, 6, 7, 0, 0, 0, 32'h1 << 6));
        vt.push_back(mk(0, RT,   0, 0, 0, 0, 0, 0, 32'h1 << 6));
        vt.push_back(mk(0, RT,   0, 0, 0, 0, 0, 0, 32'h0));
        vt.push_back(mk(1, LUI,  0, 7, 0, 0, 0, 1, 32'h0));
        vt.push_back(mk(1, ADDI, 7, 7, 0, 0, 0, 1, 32'h1 << 7));
        vt.push_back(mk(0, RT,   0, 0, 0, 0, 0, 0, 32'h1 << 7));
        vt.push_back(mk(0, RT,   0, 0, 0, 0, 0, 0, 32'h0));

        for (int r = 0; r < NREGS; r++) begin rem[r] = 0; rem_load[r] = 0; end
        @(posedge clk);
        #1;

        // Reset state: outputs quiet while reset is high, scoreboard empty afterwards.
        apply(1, RT, 1, 2, 3, 0, 0, 1);
        check("reset_stall", stall, 1'b0);
        check("reset_issue", issue, 1'b0);
        tick();
        apply(0, RT, 0, 0, 0, 0, 0, 0);
        check("reset_pending", pending, 32'h0);
        tick();

        foreach (vt[i]) begin
            apply(vt[i].v, vt[i].op, vt[i].rs, vt[i].rt, vt[i].rd, 0, vt[i].f, 0);
            check($sformatf("vec%0d_stall", i), stall, vt[i].e_stall);
            check($sformatf("vec%0d_issue", i), issue, vt[i].e_issue);
            check($sformatf("vec%0d_pending", i), pending, vt[i].e_pend);
            tick();
        end

        run_until_issue("alu_prod", RT, 1, 2, 3, 0);
        run_until_issue("alu_beq", BEQ, 3, 4, 0, 1);
        idle(3);
        run_until_issue("lw_prod", LW, 1, 3, 0, 0);
        run_until_issue("lw_beq", BEQ, 4, 3, 0, 2);
        idle(3);

        // Hold freezes the scoreboard; the dependent ADD then still needs its one stall.
        run_until_issue("lw_r8", LW, 0, 8, 0, 0);
        for (int k = 0; k < 3; k++) begin
            apply(1, RT, 8, 1, 9, 1, 0, 0);
            check("hold_issue", issue, 1'b0);
            check("hold_pending8", pending[8], 1'b1);
            check("hold_stall", stall, 1'b1);
            tick();
        end
        run_until_issue("after_hold", RT, 8, 1, 9, 1);
        idle(3);

        // Reset in the middle of a load-use hazard.
        run_until_issue("lw_r9", LW, 0, 9, 0, 0);
        apply(1, SW, 9, 0, 0, 0, 0, 1);
        check("midreset_stall", stall, 1'b0);
        check("midreset_issue", issue, 1'b0);
        tick();
        apply(1, SW, 9, 0, 0, 0, 0, 0);
        check("postreset_stall", stall, 1'b0);
        check("postreset_pending", pending, 32'h0);
        tick();
        idle(2);

`ifdef STALL_STATS_EN
        apply(0, RT, 0, 0, 0, 0, 0, 1);
        tick();
        check("stats_reset", {stall_cycles, load_stalls}, 64'h0);
        run_until_issue("stat_lw", LW, 0, 2, 0, 0);
        run_until_issue("stat_beq", BEQ, 2, 1, 0, 2);
        check("stall_cycles", stall_cycles, 32'd2);
        check("load_stalls", load_stalls, 32'd2);
        check("branch_stalls", branch_stalls, 32'd2);
`endif

        for (int n = 0; n < 600; n++) begin
            apply($urandom_range(0, 5) != 0, ops[$urandom_range(0, 10)],
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
            check_model($sformatf("rand%0d", n));
            tick();
        end

`ifdef STALL_STATS_EN
        apply(0, RT, 0, 0, 0, 0, 0, 0);
        check("rand_stall_cycles", stall_cycles, m_sc);
        check("rand_load_stalls", load_stalls, m_ls);
        check("rand_branch_stalls", branch_stalls, m_bs);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
